handshake_const_arbiter: RTL

Shares one constant-token source among NUM_REQ dataflow control channels. Each requester raises `ctrl_valid[i]` to request a copy of CONST_VALUE; the block arbitrates, registers the winning token in a one-entry output slot, and emits it on a single elastic output channel tagged with the winner's index. It sits between the per-branch control tokens of the dataflow graph and a downstream consumer. It replaces N duplicated constant units feeding a merge.

---
 rtl/handshake_const_pkg.sv | 17 +
 rtl/handshake_rr_arbiter.sv | 82 ++++++++
 rtl/handshake_const_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/handshake_const_pkg.sv
// rtl/handshake_const_pkg.sv - shared types, constants and helpers for the constant-token arbiter
// Purpose: slot-state enum, index-width derivation and the default constant token value.
package handshake_const_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam logic [26:0] HANDSHAKE_CONST_DEFAULT = 27'h5BA4EA6;

  // A single requester still needs a one-bit index port.
  function automatic int idx_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - request arbiter, round-robin or fixed priority
// Purpose: pick one requester per cycle and, in round-robin mode, own the search pointer.
// Build option: HANDSHAKE_CONST_ARB_RR_EN selects round-robin; otherwise lowest index wins.
// Ports:
//   clk, rst   in   clock, asynchronous active-high reset
//   req        in   NUM_REQ request vector
//   adv        in   accepted handshake; moves the pointer past the current winner
//   grant      out  one-hot grant (all zero when no request)
//   grant_idx  out  binary index of the granted requester
//   rr_ptr     out  current search start (constant 0 in fixed-priority build)
module handshake_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [IDX_W-1:0]   rr_ptr
);

`ifdef HANDSHAKE_CONST_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  // Search NUM_REQ slots starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int   j;
    logic found;
    j         = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    int nxt;
    nxt      = int'(grant_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    rr_ptr_d = adv ? IDX_W'(nxt) : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  // Lowest asserted index wins; no pointer state exists in this build.
  always_comb begin
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  assign rr_ptr = '0;

  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, adv};
`endif

endmodule

// File: rtl/handshake_const_arbiter.sv
// rtl/handshake_const_arbiter.sv - shared constant-token source with arbitrated elastic output
// Purpose: arbitrate NUM_REQ token requests into a one-entry output slot carrying CONST_VALUE
//          and the winner's index.
// Build option: HANDSHAKE_CONST_ARB_RR_EN selects round-robin arbitration (default fixed priority).
// Ports:
//   clk, rst     in   clock, asynchronous active-high reset
//   ctrl_valid   in   NUM_REQ per-requester token request
//   ctrl_ready   out  NUM_REQ per-requester accept, at most one bit set
//   outs         out  DATA_WIDTH token data, always CONST_VALUE
//   outs_index   out  IDX_W index of the requester that produced the held token
//   outs_valid   out  output slot full
//   outs_ready   in   downstream accept
module handshake_const_arbiter
  import handshake_const_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REQ     = 4,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(HANDSHAKE_CONST_DEFAULT),
  parameter int                    IDX_W       = idx_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  slot_state_e      slot_q, slot_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr_unused;
  logic               can_accept;
  logic               in_hs;

  handshake_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (ctrl_valid),
    .adv       (in_hs),
    .grant     (grant),
    .grant_idx (grant_idx),
    .rr_ptr    (rr_ptr_unused)
  );

  // A full slot being drained this cycle can be refilled in the same cycle.
  assign can_accept = (slot_q == EMPTY) || outs_ready;
  assign ctrl_ready = grant & {NUM_REQ{can_accept}};
  // grant is only ever set on an asserted request, so this is the input handshake.
  assign in_hs      = can_accept && (|grant);

  always_comb begin
    slot_d = slot_q;
    idx_d  = idx_q;
    if (in_hs) begin
      slot_d = FULL;
      idx_d  = grant_idx;
    end else if (outs_ready) begin
      slot_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= EMPTY;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  assign outs       = CONST_VALUE;
  assign outs_index = idx_q;
  assign outs_valid = (slot_q == FULL);

endmodule
